// File: rtl/sample_tx_encoder_if.sv
// sample_tx_encoder_if: word handshake from the sample buffer plus byte handshake to the UART transmitter.
interface sample_tx_encoder_if #(
    parameter int WORD_BYTES = 4
);
    logic                    word_valid;
    logic [8*WORD_BYTES-1:0] word_data;
    logic [WORD_BYTES-1:0]   group_mask;
    logic                    word_ready;
    logic                    tx_busy;
    logic [7:0]              tx_data;
    logic                    tx_start;
    logic                    word_done;
    logic                    retry_err;

    modport master (
        output word_valid, word_data, group_mask, tx_busy,
        input  word_ready, tx_data, tx_start, word_done, retry_err
    );

    modport slave (
        input  word_valid, word_data, group_mask, tx_busy,
        output word_ready, tx_data, tx_start, word_done, retry_err
    );
endinterface

// File: rtl/sample_tx_encoder.sv
// sample_tx_encoder: serialises masked 32-bit capture words LSB byte first into UART transmit handshakes.
module sample_tx_encoder #(
    parameter int WORD_BYTES   = 4,
    parameter int BUSY_TIMEOUT = 15
) (
    input logic                clock,
    input logic                reset_n,
    sample_tx_encoder_if.slave bus
);
    localparam int IW = $clog2(WORD_BYTES + 1);
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, SELECT, ISSUE, WAIT_HI, WAIT_LO, FINISH} state_t;

    state_t                  state;
    logic [8*WORD_BYTES-1:0] data_q;
    logic [WORD_BYTES-1:0]   mask_q;
    logic [IW-1:0]           idx;
    logic [IW-1:0]           lane;
    logic [CW-1:0]           cnt;
    logic                    found;
    logic [7:0]              lane_byte;

    // Lowest enabled lane at or above the current index.
    always_comb begin
        found = 1'b0;
        lane  = '0;
        for (int i = WORD_BYTES - 1; i >= 0; i--)
            if (mask_q[i] && IW'(i) >= idx) begin
                found = 1'b1;
                lane  = IW'(i);
            end
    end

    assign lane_byte = 8'(data_q >> (8 * idx));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= IDLE;
            data_q        <= '0;
            mask_q        <= '0;
            idx           <= '0;
            cnt           <= '0;
            bus.word_ready <= 1'b1;
            bus.tx_data   <= 8'h00;
            bus.tx_start  <= 1'b0;
            bus.word_done <= 1'b0;
            bus.retry_err <= 1'b0;
        end else begin
            bus.tx_start  <= 1'b0;
            bus.word_done <= 1'b0;
            case (state)
                IDLE:
                    if (bus.word_valid) begin
                        data_q         <= bus.word_data;
                        mask_q         <= bus.group_mask;
                        idx            <= '0;
                        bus.word_ready <= 1'b0;
                        state          <= SELECT;
                    end
                SELECT: begin
                    idx   <= found ? lane : idx;
                    state <= found ? ISSUE : FINISH;
                end
                ISSUE:
                    if (!bus.tx_busy) begin
                        bus.tx_data  <= lane_byte;
                        bus.tx_start <= 1'b1;
                        cnt          <= '0;
                        state        <= WAIT_HI;
                    end
                WAIT_HI:
                    if (bus.tx_busy)
                        state <= WAIT_LO;
                    else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
                        bus.retry_err <= 1'b1;
                        state         <= ISSUE;
                    end else
                        cnt <= cnt + 1'b1;
                WAIT_LO:
                    if (!bus.tx_busy) begin
                        idx   <= idx + 1'b1;
                        state <= SELECT;
                    end
                FINISH: begin
                    bus.word_done  <= 1'b1;
                    bus.word_ready <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sample_tx_encoder.sv
// tb_sample_tx_encoder: directed scenarios against a simple UART transmitter model.
module tb_sample_tx_encoder;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic busy = 1'b0;
    always #5 clock = ~clock;

    sample_tx_encoder_if bus ();
    assign bus.tx_busy = busy;

    sample_tx_encoder dut (.clock(clock), .reset_n(reset_n), .bus(bus));

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [7:0] log_b [0:15];
    int nb = 0, pulses = 0, done_cnt = 0, done_edge = 0, first_done_edge = 0;
    int start1 = 0, start2 = 0, fall_edge = 0, ignore = 0, bsy_cnt = 0;
    logic arm = 1'b0;

    // Transmitter model: busy rises one cycle after an accepted start and holds 10 cycles.
    always @(negedge clock) begin
        if (bsy_cnt > 0) begin
            bsy_cnt--;
            if (bsy_cnt == 0) begin
                busy = 1'b0;
                fall_edge = cyc - 1;
            end
        end else if (arm) begin
            arm = 1'b0;
            busy = 1'b1;
            bsy_cnt = 10;
        end
        if (bus.tx_start === 1'b1) begin
            pulses++;
            if (pulses == 1) start1 = cyc - 1;
            if (pulses == 2) start2 = cyc - 1;
            if (ignore > 0) ignore--;
            else begin
                arm = 1'b1;
                if (nb < 16) log_b[nb] = bus.tx_data;
                nb++;
            end
        end
        if (bus.word_done === 1'b1) begin
            if (done_cnt == 0) first_done_edge = cyc - 1;
            done_cnt++;
            done_edge = cyc - 1;
        end
    end

    task automatic clear_log();
        @(posedge clock);
        nb = 0; pulses = 0; done_cnt = 0; done_edge = 0; first_done_edge = 0;
        start1 = 0; start2 = 0; ignore = 0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic [3:0] m, output int acc);
        @(negedge clock);
        bus.word_valid = 1'b1;
        bus.word_data = d;
        bus.group_mask = m;
        acc = -1;
        for (int i = 0; i < 300 && acc < 0; i++) begin
            if (bus.word_ready) acc = cyc;
            @(negedge clock);
        end
        bus.word_valid = 1'b0;
        if (acc < 0) begin
            checks++; errors++;
            $display("FAIL send_word: word_ready never seen, required 1");
        end
    endtask

    task automatic wait_done(input int target, input int limit);
        for (int i = 0; i < limit && done_cnt < target; i++) @(negedge clock);
        if (done_cnt < target) begin
            checks++; errors++;
            $display("FAIL wait_done: done count %0d, required %0d", done_cnt, target);
        end
        repeat (4) @(negedge clock);
    endtask

    task automatic test_reset();
        bus.word_valid = 1'b1;
        bus.word_data = 32'hA1B2C3D4;
        bus.group_mask = 4'hF;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (bus.word_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", bus.word_ready); end
        checks++; if (bus.tx_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b required 0", bus.tx_start); end
        checks++; if (bus.word_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", bus.word_done); end
        checks++; if (bus.retry_err !== 1'b0) begin errors++; $display("FAIL reset_retry: got %b required 0", bus.retry_err); end
        checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h required 00", bus.tx_data); end
        bus.word_valid = 1'b0;
        reset_n = 1'b1;
        repeat (20) @(negedge clock);
        checks++; if (pulses !== 0) begin errors++; $display("FAIL reset_no_accept: pulses %0d required 0", pulses); end
        checks++; if (bus.word_ready !== 1'b1) begin errors++; $display("FAIL reset_idle_ready: got %b required 1", bus.word_ready); end
    endtask

    task automatic test_full_word();
        int acc;
        clear_log();
        send_word(32'hA1B2C3D4, 4'hF, acc);
        wait_done(1, 300);
        checks++; if (nb !== 4) begin errors++; $display("FAIL full_count: got %0d bytes required 4", nb); end
        checks++; if ({log_b[3], log_b[2], log_b[1], log_b[0]} !== 32'hA1B2C3D4) begin errors++; $display("FAIL full_bytes: got %h required a1b2c3d4", {log_b[3], log_b[2], log_b[1], log_b[0]}); end
        checks++; if (pulses !== 4) begin errors++; $display("FAIL full_pulses: got %0d required 4", pulses); end
        checks++; if (start1 - acc !== 2) begin errors++; $display("FAIL full_latency: got %0d required 2", start1 - acc); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL full_done_count: got %0d required 1", done_cnt); end
        checks++; if (done_edge - fall_edge !== 3) begin errors++; $display("FAIL full_done_timing: got %0d required 3", done_edge - fall_edge); end
        checks++; if (bus.retry_err !== 1'b0) begin errors++; $display("FAIL full_retry: got %b required 0", bus.retry_err); end
    endtask

    task automatic test_sparse_mask();
        int acc;
        clear_log();
        send_word(32'h11223344, 4'b1010, acc);
        wait_done(1, 300);
        checks++; if (nb !== 2) begin errors++; $display("FAIL sparse_count: got %0d required 2", nb); end
        checks++; if ({log_b[1], log_b[0]} !== 16'h1133) begin errors++; $display("FAIL sparse_bytes: got %h required 1133", {log_b[1], log_b[0]}); end
        checks++; if (pulses !== 2) begin errors++; $display("FAIL sparse_pulses: got %0d required 2", pulses); end
        clear_log();
        send_word(32'hDEADBEEF, 4'h0, acc);
        wait_done(1, 50);
        checks++; if (pulses !== 0) begin errors++; $display("FAIL empty_pulses: got %0d required 0", pulses); end
        checks++; if (done_edge - acc !== 2) begin errors++; $display("FAIL empty_done_timing: got %0d required 2", done_edge - acc); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL empty_done_count: got %0d required 1", done_cnt); end
    endtask

    task automatic test_back_to_back();
        int acc1, acc2;
        clear_log();
        @(negedge clock);
        bus.word_valid = 1'b1;
        bus.word_data = 32'h11223344;
        bus.group_mask = 4'h3;
        acc1 = -1;
        acc2 = -1;
        for (int i = 0; i < 400 && acc2 < 0; i++) begin
            if (bus.word_ready) begin
                if (acc1 < 0) acc1 = cyc;
                else acc2 = cyc;
            end
            @(negedge clock);
            if (acc1 >= 0 && acc2 < 0) bus.word_data = 32'h00005566;
        end
        bus.word_valid = 1'b0;
        checks++; if (acc2 < 0) begin errors++; $display("FAIL b2b_second_accept: never accepted, required accept"); end
        wait_done(2, 400);
        checks++; if (acc2 - first_done_edge !== 1) begin errors++; $display("FAIL b2b_accept_gap: got %0d required 1", acc2 - first_done_edge); end
        checks++; if (nb !== 4) begin errors++; $display("FAIL b2b_count: got %0d required 4", nb); end
        checks++; if ({log_b[3], log_b[2], log_b[1], log_b[0]} !== 32'h55663344) begin errors++; $display("FAIL b2b_bytes: got %h required 55663344", {log_b[3], log_b[2], log_b[1], log_b[0]}); end
        checks++; if (done_cnt !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d required 2", done_cnt); end
    endtask

    task automatic test_timeout();
        int acc;
        clear_log();
        ignore = 1;
        send_word(32'hA1B2C3D4, 4'h3, acc);
        wait_done(1, 300);
        checks++; if (pulses !== 3) begin errors++; $display("FAIL timeout_pulses: got %0d required 3", pulses); end
        checks++; if (start2 - start1 !== 16) begin errors++; $display("FAIL timeout_reissue_gap: got %0d required 16", start2 - start1); end
        checks++; if (nb !== 2) begin errors++; $display("FAIL timeout_count: got %0d required 2", nb); end
        checks++; if ({log_b[1], log_b[0]} !== 16'hC3D4) begin errors++; $display("FAIL timeout_bytes: got %h required c3d4", {log_b[1], log_b[0]}); end
        checks++; if (bus.retry_err !== 1'b1) begin errors++; $display("FAIL timeout_retry: got %b required 1", bus.retry_err); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL timeout_done_count: got %0d required 1", done_cnt); end
    endtask

    task automatic test_reset_mid_word();
        int acc;
        clear_log();
        send_word(32'hA1B2C3D4, 4'hF, acc);
        for (int i = 0; i < 200 && pulses < 2; i++) @(negedge clock);
        checks++; if (pulses < 2) begin errors++; $display("FAIL mid_second_start: pulses %0d required 2", pulses); end
        repeat (3) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        checks++; if (bus.tx_start !== 1'b0) begin errors++; $display("FAIL mid_start_drop: got %b required 0", bus.tx_start); end
        reset_n = 1'b1;
        @(negedge clock);
        checks++; if (bus.word_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b required 1", bus.word_ready); end
        checks++; if (bus.retry_err !== 1'b0) begin errors++; $display("FAIL mid_retry_cleared: got %b required 0", bus.retry_err); end
        repeat (30) @(negedge clock);
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL mid_no_done: got %0d required 0", done_cnt); end
        checks++; if (pulses !== 2) begin errors++; $display("FAIL mid_no_more_starts: got %0d required 2", pulses); end
        clear_log();
        send_word(32'h55667788, 4'h3, acc);
        wait_done(1, 300);
        checks++; if (nb !== 2) begin errors++; $display("FAIL mid_new_count: got %0d required 2", nb); end
        checks++; if ({log_b[1], log_b[0]} !== 16'h7788) begin errors++; $display("FAIL mid_new_bytes: got %h required 7788", {log_b[1], log_b[0]}); end
        checks++; if (start1 - acc !== 2) begin errors++; $display("FAIL mid_new_latency: got %0d required 2", start1 - acc); end
    endtask

    initial begin
        bus.word_valid = 1'b0;
        bus.word_data = 32'h0;
        bus.group_mask = 4'h0;
        test_reset();
        test_full_word();
        test_sparse_mask();
        test_back_to_back();
        test_timeout();
        test_reset_mid_word();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
